// File: rtl/frame_write_scheduler_if.sv
// frame_write_scheduler_if: handshake and SRAM-port bundle between the scheduler and its environment
interface frame_write_scheduler_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic              start;
  logic              pg_reset;
  logic              pg_enable;
  logic              pg_done;
  logic              p0_wren;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_data;
  logic              p1_wren;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_data;
  logic              mem_busy;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [1:0]        overflow;
  logic              busy;
  logic              seq_done;
  modport master (
    output start, pg_done, p0_wren, p0_addr, p0_data, p1_wren, p1_addr, p1_data, mem_busy,
    input  pg_reset, pg_enable, mem_wren, mem_addr, mem_data, overflow, busy, seq_done
  );
  modport slave (
    input  start, pg_done, p0_wren, p0_addr, p0_data, p1_wren, p1_addr, p1_data, mem_busy,
    output pg_reset, pg_enable, mem_wren, mem_addr, mem_data, overflow, busy, seq_done
  );
endinterface

// File: rtl/frame_write_scheduler.sv
// frame_write_scheduler: two-port FIFO + round-robin share of the frame-SRAM write port, with pattern-fill sequencer
module frame_write_scheduler #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset_n,
  frame_write_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  logic rst_meta_q, rst_sync_q;
  logic [1:0] wren_in, empty, push, pop, ovf_q, ovf_d;
  logic [1:0][ADDR_W-1:0] head_addr;
  logic [1:0][DATA_W-1:0] head_data;
  logic do_pop, grant1, rr_last_q, start_ok;
  logic mem_wren_q, pg_reset_q, pg_enable_q, seq_done_q, busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  state_t state_q;

  // Reset asserts asynchronously but is released only on a clock edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {rst_meta_q, rst_sync_q} <= 2'b00;
    else {rst_meta_q, rst_sync_q} <= {1'b1, rst_meta_q};

  assign wren_in = {bus.p1_wren, bus.p0_wren};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [ADDR_W-1:0] a_q [FIFO_DEPTH];
    logic [DATA_W-1:0] d_q [FIFO_DEPTH];
    ptr_t wp_q, rp_q;
    logic full;
    assign empty[g] = wp_q == rp_q;
    assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign push[g] = wren_in[g] && (!full || pop[g]);
    assign head_addr[g] = a_q[rp_q[AW-1:0]];
    assign head_data[g] = d_q[rp_q[AW-1:0]];
    always_ff @(posedge clk)
      if (push[g]) begin
        a_q[wp_q[AW-1:0]] <= g ? bus.p1_addr : bus.p0_addr;
        d_q[wp_q[AW-1:0]] <= g ? bus.p1_data : bus.p0_data;
      end
    always_ff @(posedge clk or negedge rst_sync_q)
      if (!rst_sync_q) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push[g]) wp_q <= wp_q + ptr_t'(1);
        if (pop[g]) rp_q <= rp_q + ptr_t'(1);
      end
  end

  // Port 1 wins when port 0 is empty or port 0 was the last one served
  assign do_pop = !bus.mem_busy && (empty != 2'b11);
  assign grant1 = !empty[1] && (empty[0] || !rr_last_q);
  assign pop = {do_pop && grant1, do_pop && !grant1};
  assign start_ok = bus.start && (state_q == IDLE);
  assign ovf_d = (start_ok ? 2'b00 : ovf_q) | (wren_in & ~push);

  always_ff @(posedge clk or negedge rst_sync_q)
    if (!rst_sync_q) begin
      mem_wren_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rr_last_q  <= 1'b1;
      ovf_q      <= 2'b00;
    end else begin
      mem_wren_q <= do_pop;
      ovf_q      <= ovf_d;
      if (do_pop) begin
        mem_addr_q <= grant1 ? head_addr[1] : head_addr[0];
        mem_data_q <= grant1 ? head_data[1] : head_data[0];
        rr_last_q  <= grant1;
      end
    end

  always_ff @(posedge clk or negedge rst_sync_q)
    if (!rst_sync_q) begin
      state_q     <= IDLE;
      pg_reset_q  <= 1'b0;
      pg_enable_q <= 1'b0;
      seq_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q    <= CLEAR;
          pg_reset_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        CLEAR: begin
          state_q     <= RUN;
          pg_reset_q  <= 1'b0;
          pg_enable_q <= 1'b1;
        end
        RUN: if (bus.pg_done) begin
          state_q     <= DRAIN;
          pg_enable_q <= 1'b0;
        end
        DRAIN: if (empty[0] && !bus.p0_wren) begin
          state_q    <= DONE;
          seq_done_q <= 1'b1;
        end
        DONE: begin
          state_q    <= IDLE;
          seq_done_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end

  assign bus.mem_wren  = mem_wren_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.overflow  = ovf_q;
  assign bus.pg_reset  = pg_reset_q;
  assign bus.pg_enable = pg_enable_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_frame_write_scheduler.sv
// tb_frame_write_scheduler: directed vector table plus hand sequences for the frame write scheduler
module tb_frame_write_scheduler;
  localparam int AW = 18;
  localparam int DW = 32;

  typedef struct {
    logic          w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          mb;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [1:0]    eo;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int vecs = 0;
  int errs = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  frame_write_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  frame_write_scheduler #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.pg_done = 0; bus.mem_busy = 0;
    bus.p0_wren = 0; bus.p0_addr = '0; bus.p0_data = '0;
    bus.p1_wren = 0; bus.p1_addr = '0; bus.p1_data = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pg_reset"}, bus.pg_reset, 0);
    chk({tag, " pg_enable"}, bus.pg_enable, 0);
    chk({tag, " mem_wren"}, bus.mem_wren, 0);
    chk({tag, " mem_addr"}, bus.mem_addr, 0);
    chk({tag, " mem_data"}, bus.mem_data, 0);
    chk({tag, " overflow"}, bus.overflow, 0);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " seq_done"}, bus.seq_done, 0);
  endtask

  initial begin
    int rst_cnt, en_cnt, done_cnt, last_wr, done_cyc, wr_cnt;
    logic [AW-1:0] wr_addr;
    idle_inputs();
    #2 reset_n = 0;
    repeat (3) step();
    chk_all_zero("reset");
    reset_n = 1;
    repeat (3) step();
    chk_all_zero("post_reset");

    // Port 0 three words, then busy-held overflow of a depth-4 FIFO
    tbl.push_back(vec_t'{1, 'h10, 'hA, 0, 0, 0, 0, 2'b00});
    tbl.push_back(vec_t'{1, 'h11, 'hB, 0, 0, 0, 0, 2'b00});
    tbl.push_back(vec_t'{1, 'h12, 'hC, 0, 1, 'h10, 'hA, 2'b00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 'h11, 'hB, 2'b00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 'h12, 'hC, 2'b00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 2'b00});
    tbl.push_back(vec_t'{1, 'h20, 'h100, 1, 0, 0, 0, 2'b00});
    tbl.push_back(vec_t'{1, 'h21, 'h101, 1, 0, 0, 0, 2'b00});
    tbl.push_back(vec_t'{1, 'h22, 'h102, 1, 0, 0, 0, 2'b00});
    tbl.push_back(vec_t'{1, 'h23, 'h103, 1, 0, 0, 0, 2'b00});
    tbl.push_back(vec_t'{1, 'h24, 'h104, 1, 0, 0, 0, 2'b00});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 2'b01});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 2'b01});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 'h20, 'h100, 2'b01});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 'h21, 'h101, 2'b01});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 'h22, 'h102, 2'b01});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 'h23, 'h103, 2'b01});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 2'b01});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 2'b01});
    foreach (tbl[i]) begin
      step();
      bus.p0_wren = tbl[i].w0; bus.p0_addr = tbl[i].a0; bus.p0_data = tbl[i].d0;
      bus.mem_busy = tbl[i].mb;
      chk($sformatf("tbl%0d mem_wren", i), bus.mem_wren, tbl[i].ew);
      chk($sformatf("tbl%0d overflow", i), bus.overflow, tbl[i].eo);
      if (tbl[i].ew) begin
        chk($sformatf("tbl%0d mem_addr", i), bus.mem_addr, tbl[i].ea);
        chk($sformatf("tbl%0d mem_data", i), bus.mem_data, tbl[i].ed);
      end
    end
    chk("hold mem_addr", bus.mem_addr, 'h23);
    chk("hold mem_data", bus.mem_data, 'h103);

    // Pattern-fill run; a stray start during RUN must be ignored
    step(); idle_inputs(); bus.start = 1;
    step(); bus.start = 0;
    chk("run pg_reset", bus.pg_reset, 1);
    chk("run busy", bus.busy, 1);
    chk("run overflow cleared", bus.overflow, 0);
    rst_cnt = 1; en_cnt = 0; done_cnt = 0; last_wr = -1; done_cyc = -1; wr_addr = '0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (bus.pg_reset) rst_cnt++;
      if (bus.pg_enable) en_cnt++;
      if (bus.mem_wren) begin last_wr = c; wr_addr = bus.mem_addr; end
      if (bus.seq_done) begin done_cnt++; done_cyc = c; end
      bus.start = bus.pg_enable && (en_cnt == 5);
      bus.pg_done = (en_cnt >= 20) && (done_cnt == 0);
      bus.p0_wren = bus.pg_enable && (en_cnt == 20);
      bus.p0_addr = 'h300; bus.p0_data = 'h3AB;
      if (done_cnt != 0 && c > done_cyc + 2) break;
    end
    idle_inputs();
    chk("run pg_reset cycles", rst_cnt, 1);
    chk("run pg_enable cycles", en_cnt, 20);
    chk("run seq_done pulses", done_cnt, 1);
    chk("run seq_done after last write", done_cyc, last_wr + 1);
    chk("run last write addr", wr_addr, 'h300);
    chk("run busy after", bus.busy, 0);

    // Both ports streaming, port 1 one cycle behind
    wr_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      int k;
      logic ew;
      step();
      bus.p0_wren = (c < 8); bus.p0_addr = AW'('h100 + c); bus.p0_data = DW'('h1000 + c);
      bus.p1_wren = (c >= 1 && c < 9); bus.p1_addr = AW'('h200 + c - 1); bus.p1_data = DW'('h2000 + c - 1);
      k = c - 2;
      ew = (c >= 2 && c <= 17);
      if (bus.mem_wren) wr_cnt++;
      chk($sformatf("rr%0d mem_wren", c), bus.mem_wren, ew);
      if (ew) begin
        chk($sformatf("rr%0d mem_addr", c), bus.mem_addr, (k % 2) ? 'h200 + k / 2 : 'h100 + k / 2);
        chk($sformatf("rr%0d mem_data", c), bus.mem_data, (k % 2) ? 'h2000 + k / 2 : 'h1000 + k / 2);
      end
    end
    idle_inputs();
    chk("rr write count", wr_cnt, 16);
    chk("rr overflow", bus.overflow, 0);

    // Reset mid-run with port 0 FIFO holding words
    step(); bus.mem_busy = 1; bus.start = 1; bus.p0_wren = 1; bus.p0_addr = 'h50; bus.p0_data = 'h55;
    step(); bus.start = 0; bus.p0_addr = 'h51; bus.p0_data = 'h56;
    step(); bus.p0_wren = 0;
    step();
    chk("pre-reset pg_enable", bus.pg_enable, 1);
    #2 reset_n = 0;
    #1;
    chk_all_zero("midrun_reset");
    step(); step();
    reset_n = 1; bus.mem_busy = 0;
    wr_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.mem_wren) wr_cnt++;
    end
    chk("post-reset stale writes", wr_cnt, 0);
    chk("post-reset busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
